// File: rtl/stall_ctrl.sv
// stall_ctrl: hazard scheduler for the 5-stage core.
// Holds PC/IF/ID while a loaded register is not yet forwardable.
// Holds PC/IF/ID/EX while the multi-cycle divider is busy.
// Optional macro STALL_PERF_CNT_EN adds the perf_lu_cycles and perf_div_cycles counters.
module stall_ctrl #(
  parameter int LOAD_LAT   = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       flush,
  input  logic       id_valid,
  input  logic       id_re1,
  input  logic [4:0] id_raddr1,
  input  logic       id_re2,
  input  logic [4:0] id_raddr2,
  input  logic       id_we,
  input  logic [4:0] id_waddr,
  input  logic       id_is_load,
  input  logic       id_is_div,
  output logic [5:0] stall,
  output logic       id_issue,
  output logic       div_start,
  output logic       div_busy,
  output logic       div_done
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_cycles,
  output logic [31:0] perf_div_cycles
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] LL    = 2'(LOAD_LAT);
  localparam logic [5:0] DLOAD = 6'(DIV_CYCLES - 1);

  // Scoreboard for r1..r31 only. r0 is tied to zero in the read view.
  logic [31:1][1:0] r_cnt;
  logic [31:0][1:0] w_cnt;
  logic [1:0]       r_state;
  logic [5:0]       r_dcnt;

  logic w_hz1, w_hz2, w_hazard, w_set;

  assign w_cnt = {r_cnt, 2'b00};

  // Read-side hazard check against pending loads.
  assign w_hz1    = id_re1 & (id_raddr1 != 5'd0) & (w_cnt[id_raddr1] != 2'd0);
  assign w_hz2    = id_re2 & (id_raddr2 != 5'd0) & (w_cnt[id_raddr2] != 2'd0);
  assign w_hazard = id_valid & (w_hz1 | w_hz2);

  assign div_busy  = (r_state == S_BUSY);
  assign div_done  = (r_state == S_DONE);
  assign id_issue  = id_valid & ~w_hazard & ~div_busy & ~flush;
  assign div_start = id_issue & id_is_div;
  assign w_set     = id_issue & id_is_load & id_we & (id_waddr != 5'd0);
  assign stall     = (w_hazard ? 6'b000111 : 6'b000000) | (div_busy ? 6'b001111 : 6'b000000);

  // Per-register load-latency countdown.
  // A new load set takes priority over the decrement; flush clears everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (flush)                              r_cnt[i] <= 2'd0;
        else if (w_set && id_waddr == 5'(i))    r_cnt[i] <= LL;
        else if (r_cnt[i] != 2'd0)              r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

  // Divider occupancy FSM.
  // The state sequence is IDLE -> BUSY (DIV_CYCLES cycles) -> DONE (1 cycle) -> IDLE.
  // DONE does not raise div_busy, so a start presented in DONE is honoured rather than dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_dcnt  <= 6'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_dcnt  <= 6'd0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (r_dcnt == 6'd0) r_state <= S_DONE;
          else                r_dcnt  <= r_dcnt - 6'd1;
        end
        default: begin
          if (div_start) begin
            r_state <= S_BUSY;
            r_dcnt  <= DLOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

`ifdef STALL_PERF_CNT_EN
  // Stall-cause cycle counters.
  // They wrap naturally, are cleared only by reset, and ignore flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lu_cycles  <= 32'd0;
      perf_div_cycles <= 32'd0;
    end else begin
      if (w_hazard) perf_lu_cycles  <= perf_lu_cycles + 32'd1;
      if (div_busy) perf_div_cycles <= perf_div_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl.
// The driver pushes the expected outputs from a cycle-count reference model.
// The monitor pops each entry and compares it with the DUT on the falling edge.
module tb_stall_ctrl;
  localparam int LOAD_LAT   = 1;
  localparam int DIV_CYCLES = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0, id_valid = 1'b0, id_re1 = 1'b0, id_re2 = 1'b0, id_we = 1'b0;
  logic [4:0] id_raddr1 = '0, id_raddr2 = '0, id_waddr = '0;
  logic       id_is_load = 1'b0, id_is_div = 1'b0;
  logic [5:0] stall;
  logic       id_issue, div_start, div_busy, div_done;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_cycles, perf_div_cycles;
`endif

  stall_ctrl #(.LOAD_LAT(LOAD_LAT), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .id_valid(id_valid),
    .id_re1(id_re1), .id_raddr1(id_raddr1), .id_re2(id_re2), .id_raddr2(id_raddr2),
    .id_we(id_we), .id_waddr(id_waddr), .id_is_load(id_is_load), .id_is_div(id_is_div),
    .stall(stall), .id_issue(id_issue), .div_start(div_start),
    .div_busy(div_busy), .div_done(div_done)
`ifdef STALL_PERF_CNT_EN
    , .perf_lu_cycles(perf_lu_cycles), .perf_div_cycles(perf_div_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] stall;
    logic       issue, start, busy, done;
  } exp_t;

  exp_t q[$];
  int vectors = 0, errors = 0;

  // Reference model state.
  // pend[r] holds the cycles left until r is forwardable.
  // div_rem holds the busy cycles still ahead.
  int pend[32];
  int div_rem = 0;
  bit done_f = 0;
  int perf_lu = 0, perf_dv = 0;

  task automatic model_reset();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    div_rem = 0; done_f = 0; perf_lu = 0; perf_dv = 0;
  endtask

  // Drive one ID cycle, push its expectation, advance the model, then move to the next cycle.
  task automatic step(input bit v, input bit r1, input int a1, input bit r2, input int a2,
                      input bit we, input int wa, input bit ld, input bit dv, input bit fl);
    exp_t e;
    bit haz, busy, iss;
    id_valid = v; id_re1 = r1; id_raddr1 = 5'(a1); id_re2 = r2; id_raddr2 = 5'(a2);
    id_we = we; id_waddr = 5'(wa); id_is_load = ld; id_is_div = dv; flush = fl;
    haz  = v && ((r1 && a1 != 0 && pend[a1] > 0) || (r2 && a2 != 0 && pend[a2] > 0));
    busy = (div_rem > 0);
    iss  = v && !haz && !busy && !fl;
    e.stall = (haz ? 6'b000111 : 6'b0) | (busy ? 6'b001111 : 6'b0);
    e.issue = iss; e.start = iss && dv; e.busy = busy; e.done = done_f;
    q.push_back(e);
    perf_lu += int'(haz); perf_dv += int'(busy);
    if (fl) begin
      for (int r = 0; r < 32; r++) pend[r] = 0;
      div_rem = 0; done_f = 0;
    end else begin
      for (int r = 0; r < 32; r++) if (pend[r] > 0) pend[r]--;
      if (iss && ld && we && wa != 0) pend[wa] = LOAD_LAT;
      if (div_rem > 0) begin
        done_f = (div_rem == 1);
        div_rem--;
      end else begin
        done_f = 0;
        if (iss && dv) div_rem = DIV_CYCLES;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      if (stall !== e.stall || id_issue !== e.issue || div_start !== e.start ||
          div_busy !== e.busy || div_done !== e.done) begin
        errors++;
        $display("FAIL cycle_out t=%0t got stall=%b issue=%b start=%b busy=%b done=%b want stall=%b issue=%b start=%b busy=%b done=%b",
                 $time, stall, id_issue, div_start, div_busy, div_done,
                 e.stall, e.issue, e.start, e.busy, e.done);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stall !== 6'b0 || id_issue !== 1'b0 || div_start !== 1'b0 || div_busy !== 1'b0 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got stall=%b busy=%b done=%b want all zero", stall, div_busy, div_done);
    end
    @(posedge clk); #1; resetn = 1'b1;

    // Load followed by a use through rs: one stall cycle, then the use issues.
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(1, 1, 5, 0, 0, 1, 2, 0, 0, 0);
    step(1, 1, 5, 0, 0, 1, 2, 0, 0, 0);
    // A load to r0 followed by a read of r0, and a load of r5 followed by a read of r6: no stall.
    step(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
    step(1, 1, 6, 1, 6, 0, 0, 0, 0, 0);
    // Both operands read the pending register and still produce a single stall.
    step(1, 0, 0, 0, 0, 1, 9, 1, 0, 0);
    step(1, 1, 9, 1, 9, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 9, 0, 0, 0, 0, 0);
    // A load that reads its own destination is not a hazard with itself.
    step(1, 1, 4, 0, 0, 1, 4, 1, 0, 0);
    // Divide: 32 busy cycles, done on cycle 33, and a second divide issued on cycle 34.
    step(1, 1, 1, 1, 2, 1, 0, 0, 1, 0);
    nop(33);
    step(1, 1, 1, 1, 2, 1, 0, 0, 1, 0);
    // Flush when the divider count reaches 10, then a load of r7 issued under flush.
    nop(21);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 1);
    step(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    nop(3);
    // Overlap: an instruction flagged both load and div, followed by a read of its destination.
    step(1, 0, 0, 0, 0, 1, 11, 1, 1, 0);
    step(1, 1, 11, 0, 0, 0, 0, 0, 0, 0);
    nop(3);
    // Asynchronous reset while the divider is busy.
    @(negedge clk); #2;
    resetn = 1'b0; #1;
    vectors++;
    if (stall !== 6'b0 || div_busy !== 1'b0 || div_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got stall=%b busy=%b done=%b want all zero", stall, div_busy, div_done);
    end
    model_reset();
    @(posedge clk); #1; resetn = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit v, r1, r2, we, ld, dv, fl;
      int a1, a2, wa;
      v  = ($urandom_range(0, 3) != 0);
      r1 = $urandom_range(0, 1); r2 = $urandom_range(0, 1);
      a1 = $urandom_range(0, 7); a2 = $urandom_range(0, 7); wa = $urandom_range(0, 7);
      we = ($urandom_range(0, 3) != 0);
      ld = ($urandom_range(0, 2) == 0);
      dv = ($urandom_range(0, 19) == 0) && !done_f;
      if (dv && $urandom_range(0, 3) != 0) ld = 0;
      fl = ($urandom_range(0, 49) == 0);
      step(v, r1, a1, r2, a2, we, wa, ld, dv, fl);
    end
    nop(1);
    @(negedge clk); #1;
`ifdef STALL_PERF_CNT_EN
    vectors++;
    if (perf_lu_cycles !== 32'(perf_lu) || perf_div_cycles !== 32'(perf_dv)) begin
      errors++;
      $display("FAIL perf_cnt got lu=%0d div=%0d want lu=%0d div=%0d",
               perf_lu_cycles, perf_div_cycles, perf_lu, perf_dv);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage core; sits beside ID and the register file's forwarding network.
- Tracks in-flight results that the EX/MEM/WB forwarding buses cannot yet supply: a per-register load-latency scoreboard, plus a multi-cycle divider occupancy FSM.
- Drives the 6-bit stall vector that holds PC/IF/ID/EX. Bit map: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.

Parameters:
- LOAD_LAT, 1, cycles after issue before a load destination becomes forwardable (range 1..3).
- DIV_CYCLES, 32, divider busy cycles after start (range 2..63).

Ports:
- clk  in  1  core clock, rising edge
- resetn  in  1  asynchronous active-low reset
- flush  in  1  exception/eret flush; kills all tracked state
- id_valid  in  1  ID holds a valid instruction
- id_re1  in  1  ID reads rs
- id_raddr1  in  5  rs address
- id_re2  in  1  ID reads rt
- id_raddr2  in  5  rt address
- id_we  in  1  ID instruction writes a GPR
- id_waddr  in  5  destination GPR
- id_is_load  in  1  ID instruction is lb/lbu/lh/lhu/lw
- id_is_div  in  1  ID instruction is div/divu
- stall  out  6  stall vector (bit map above)
- id_issue  out  1  ID instruction advances to EX this cycle
- div_start  out  1  one-cycle pulse to the divider
- div_busy  out  1  FSM in BUSY
- div_done  out  1  one-cycle pulse on the BUSY->DONE transition cycle

Behaviour:
- Reset (resetn=0, async): all 32 scoreboard counters = 0; FSM = IDLE; div counter = 0; all outputs 0.
- Scoreboard:
  - One 2-bit down-counter per GPR; cnt[0] is never written.
  - Each cycle, a nonzero counter decrements by 1.
  - On id_issue & id_is_load & id_we & id_waddr!=0: cnt[id_waddr] <= LOAD_LAT. Set wins over decrement for the same register.
  - MEM/WB never stall, so decrement is unconditional.
- hazard (combinational) = id_valid & ((id_re1 & id_raddr1!=0 & cnt[id_raddr1]!=0) | (id_re2 & id_raddr2!=0 & cnt[id_raddr2]!=0)).
- Divider FSM:
  - IDLE: on id_issue & id_is_div -> BUSY, div counter <= DIV_CYCLES-1, div_start=1 in the issue cycle.
  - BUSY: counter decrements each cycle; at counter==0 -> DONE.
  - DONE: one cycle; div_done=1 (registered); then -> IDLE. A new div may issue in the cycle after DONE.
- id_issue = id_valid & ~hazard & ~div_busy.
- stall = (hazard ? 6'b000111 : 0) | (div_busy ? 6'b001111 : 0). Combinational from state and ID inputs, so the effect is in the same cycle.
- Latency:
  - Load followed immediately by a dependent instruction (LOAD_LAT=1): exactly 1 stall cycle.
  - div: EX is held for DIV_CYCLES cycles after the issue cycle.
- flush:
  - Synchronous. Next edge: all counters = 0, FSM = IDLE, no div_done pulse.
  - Flush overrides any set or start in the same cycle.
  - id_issue is gated by ~flush.
  - An abort mid-divide is silent; the divider sees no further start.
- Boundaries:
  - Reads of r0 never hazard.
  - Both operands hitting pending loads produce the same single stall.
  - A load whose destination equals its own source is not a hazard with itself.
  - id_is_load and id_is_div are never both 1; if they are, load tracking applies and the div is started.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined: adds outputs perf_lu_cycles[31:0] and perf_div_cycles[31:0].
  - perf_lu_cycles increments each cycle hazard=1.
  - perf_div_cycles increments each cycle div_busy=1.
  - Both wrap at 2^32, clear on resetn=0, and are unaffected by flush.
- Undefined: the ports are absent and no counter logic is built.

Test Plan:
- Reset: resetn=0 mid-BUSY -> stall=0, div_busy=0, div_done=0 immediately (async); all cnt=0.
- Load-use (LOAD_LAT=1): issue lw r5; next cycle ID reads r5 via re1 -> stall=6'b000111 for 1 cycle; id_issue=0 then 1.
- Non-dependent or r0: lw r0 then read r0; lw r5 then read r6 -> stall stays 0.
- Divide (DIV_CYCLES=32): issue div -> div_start pulse in the issue cycle; stall=6'b001111 for 32 cycles; div_done=1 on cycle 33; back-to-back div issues in cycle 34.
- Overlap: div BUSY while ID reads a pending load reg -> stall=6'b001111; no double-count of perf_lu_cycles when the hazard clears during BUSY (hazard only counts while cnt!=0).
- Flush: flush during BUSY at count 10 -> next cycle div_busy=0, no div_done; lw r7 issued with flush=1 -> cnt[7]=0, no stall on a subsequent read of r7.
